lcd_text_driver: RTL and testbench

//  Receiving end of the lcd_row/lcd_col/lcd_char/lcd_we/lcd_update/lcd_busy

---
 rtl/lcd_text_driver_if.sv | 20 ++
 rtl/lcd_text_driver.sv | 223 ++++++++++++++++++++++
 tb/tb_lcd_text_driver.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_driver_if.sv
// Character write port between the control logic and the LCD text driver.
// The control logic owns position/char/strobes; the driver reports busy.
interface lcd_text_driver_if;
  logic       lcd_row;
  logic [3:0] lcd_col;
  logic [7:0] lcd_char;
  logic       lcd_we;
  logic       lcd_update;
  logic       lcd_busy;

  modport master (
    output lcd_row, lcd_col, lcd_char, lcd_we, lcd_update,
    input  lcd_busy
  );

  modport slave (
    input  lcd_row, lcd_col, lcd_char, lcd_we, lcd_update,
    output lcd_busy
  );
endinterface

// File: rtl/lcd_text_driver.sv
// 2x16 character buffer streamed to an HD44780-style panel over a 4-bit
// write-only bus; runs the panel power-up init sequence after reset.
module lcd_text_driver #(
  parameter int E_PULSE   = 16,
  parameter int CMD_WAIT  = 3000,
  parameter int CLR_WAIT  = 110000,
  parameter int INIT_WAIT = 1000000
) (
  input  logic             CLK,
  input  logic             RST,
  lcd_text_driver_if.slave host,
  output logic [3:0]       LCD_DB,
  output logic             LCD_E,
  output logic             LCD_RS,
  output logic             LCD_RW
);

  localparam int MAX_A = (E_PULSE > CMD_WAIT) ? E_PULSE : CMD_WAIT;
  localparam int MAX_B = (CLR_WAIT > INIT_WAIT) ? CLR_WAIT : INIT_WAIT;
  localparam int MAX_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {INIT_DLY, INIT_NIB, INIT_CMD, IDLE, REFRESH} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_HIGH, PH_LOW, PH_WAIT} phase_t;

  state_t        state;
  phase_t        phase;
  logic [CW-1:0] cnt;
  // Refresh walks bytes 0..33, so the index needs six bits rather than five.
  logic [5:0]    idx;
  logic [7:0]    cur_byte;
  logic          low_nib;
  logic          single_nib;
  logic          long_wait;
  logic          pending;
  logic          busy;
  logic [7:0]    buffer [32];

  logic [5:0]    nxt_idx;
  logic [4:0]    rd_addr;
  logic [7:0]    rd_char;
  logic          wait_done;
  logic          finishing;
  logic          restart;
  logic          launch;
  logic [7:0]    nxt_val;
  logic          nxt_rs;
  logic          nxt_single;

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    case (i)
      2'd0:    init_byte = 8'h28;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (host.lcd_we)
      buffer[{host.lcd_row, host.lcd_col}] <= host.lcd_char;
  end

  // Chooses the next unit to put on the bus and whether it starts this edge.
  // A write landing on the same edge as a char fetch is forwarded.
  always_comb begin
    nxt_idx    = idx + 6'd1;
    rd_addr    = nxt_idx[4:0] - ((nxt_idx < 6'd17) ? 5'd1 : 5'd2);
    rd_char    = buffer[rd_addr];
    if (host.lcd_we && ({host.lcd_row, host.lcd_col} == rd_addr))
      rd_char = host.lcd_char;
    wait_done  = long_wait ? (cnt == CW'(CLR_WAIT - 1)) : (cnt == CW'(CMD_WAIT - 1));
    finishing  = ((state == INIT_CMD) && (idx == 6'd3)) ||
                 ((state == REFRESH)  && (idx == 6'd33));
    restart    = pending || host.lcd_update;
    nxt_val    = 8'h80;
    nxt_rs     = 1'b0;
    nxt_single = 1'b0;
    launch     = 1'b0;
    case (state)
      INIT_DLY: begin
        nxt_val    = 8'h30;
        nxt_single = 1'b1;
        launch     = (cnt == CW'(INIT_WAIT - 1));
      end
      INIT_NIB: begin
        if (idx == 6'd3) begin
          nxt_val = 8'h28;
        end else begin
          nxt_single = 1'b1;
          nxt_val    = (idx == 6'd2) ? 8'h20 : 8'h30;
        end
      end
      INIT_CMD: begin
        if (!finishing)
          nxt_val = init_byte(idx[1:0] + 2'd1);
      end
      REFRESH: begin
        if (!finishing) begin
          if (nxt_idx == 6'd17) begin
            nxt_val = 8'hC0;
          end else begin
            nxt_val = rd_char;
            nxt_rs  = 1'b1;
          end
        end
      end
      IDLE: launch = host.lcd_update;
      default: ;
    endcase
    if ((state == INIT_NIB || state == INIT_CMD || state == REFRESH) &&
        (phase == PH_WAIT) && wait_done && (!finishing || restart))
      launch = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= INIT_DLY;
      phase      <= PH_SETUP;
      cnt        <= '0;
      idx        <= '0;
      cur_byte   <= '0;
      low_nib    <= 1'b0;
      single_nib <= 1'b0;
      long_wait  <= 1'b0;
      pending    <= 1'b0;
      busy       <= 1'b1;
      LCD_E      <= 1'b0;
      LCD_RS     <= 1'b0;
      LCD_DB     <= '0;
    end else begin
      if (host.lcd_update && (state != IDLE))
        pending <= 1'b1;
      case (state)
        INIT_DLY: begin
          if (launch) begin
            state <= INIT_NIB;
            idx   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IDLE: begin
          if (host.lcd_update) begin
            state <= REFRESH;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          case (phase)
            PH_SETUP: begin
              phase <= PH_HIGH;
              LCD_E <= 1'b1;
              cnt   <= '0;
            end
            PH_HIGH: begin
              if (cnt == CW'(E_PULSE - 1)) begin
                phase <= PH_LOW;
                LCD_E <= 1'b0;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            PH_LOW: begin
              if (cnt == CW'(E_PULSE - 1)) begin
                cnt <= '0;
                if (!single_nib && !low_nib) begin
                  low_nib <= 1'b1;
                  phase   <= PH_SETUP;
                  LCD_DB  <= cur_byte[3:0];
                end else begin
                  phase <= PH_WAIT;
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            PH_WAIT: begin
              if (wait_done) begin
                if (finishing) begin
                  if (restart) begin
                    pending <= 1'b0;
                    state   <= REFRESH;
                    idx     <= '0;
                  end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                  end
                end else if ((state == INIT_NIB) && (idx == 6'd3)) begin
                  state <= INIT_CMD;
                  idx   <= '0;
                end else begin
                  idx <= nxt_idx;
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            default: ;
          endcase
        end
      endcase
      // Starting a unit overrides whatever the phase logic scheduled.
      if (launch) begin
        phase      <= PH_SETUP;
        cnt        <= '0;
        low_nib    <= 1'b0;
        single_nib <= nxt_single;
        cur_byte   <= nxt_val;
        long_wait  <= nxt_single || (!nxt_rs && (nxt_val == 8'h01));
        LCD_DB     <= nxt_val[7:4];
        LCD_RS     <= nxt_rs;
        LCD_E      <= 1'b0;
      end
    end
  end

  assign host.lcd_busy = busy;
  assign LCD_RW        = 1'b0;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Directed bench for lcd_text_driver: init timing, refresh contents, pending
// collapse, writes during refresh, mid-refresh reset and same-edge write/update.
`timescale 1ns/1ps
module tb_lcd_text_driver;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] LCD_DB;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;

  lcd_text_driver_if host();

  lcd_text_driver #(
    .E_PULSE(2), .CMD_WAIT(4), .CLR_WAIT(8), .INIT_WAIT(10)
  ) dut (
    .CLK(CLK), .RST(RST), .host(host),
    .LCD_DB(LCD_DB), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW)
  );

  always #5 CLK = ~CLK;

  int         check_count = 0;
  int         pass_count  = 0;
  logic [4:0] nib_q [$];
  logic [7:0] model [32];
  int         e_width = 0;
  int         e_bad   = 0;
  logic       prev_e  = 1'b0;
  int         cycles;

  // Panel monitor: records {RS,DB} at each E rise and polices E-high width.
  always @(negedge CLK) begin
    if (RST) begin
      e_width = 0;
      prev_e  = 1'b0;
    end else begin
      if (LCD_E && !prev_e)
        nib_q.push_back({LCD_RS, LCD_DB});
      if (LCD_E) begin
        e_width++;
      end else if (prev_e) begin
        if (e_width != 2) e_bad++;
        e_width = 0;
      end
      prev_e = LCD_E;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // One cycle of write-port activity, driven at the negedge.
  task automatic applyStimulus(input logic we, input logic row, input logic [3:0] col,
                               input logic [7:0] ch, input logic upd);
    host.lcd_we     = we;
    host.lcd_row    = row;
    host.lcd_col    = col;
    host.lcd_char   = ch;
    host.lcd_update = upd;
    if (we) model[{row, col}] = ch;
    @(negedge CLK);
    host.lcd_we     = 1'b0;
    host.lcd_update = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int expected_cycles);
    int n = 0;
    while (host.lcd_busy === 1'b1 && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    checkOutput(tag, n, expected_cycles);
  endtask

  task automatic checkInit(input string tag);
    logic [3:0] exp_nib [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
    checkOutput({tag, "_count"}, nib_q.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < nib_q.size())
        checkOutput($sformatf("%s_nib%0d", tag, i), nib_q[i], {1'b0, exp_nib[i]});
  endtask

  task automatic checkRefresh(input string tag, input int base);
    logic [8:0] exp_b;
    logic [8:0] got_b;
    for (int b = 0; b < 34; b++) begin
      if (b == 0)       exp_b = {1'b0, 8'h80};
      else if (b == 17) exp_b = {1'b0, 8'hC0};
      else if (b < 17)  exp_b = {1'b1, model[b - 1]};
      else              exp_b = {1'b1, model[b - 2]};
      if (base + 2 * b + 1 < nib_q.size()) begin
        got_b = {nib_q[base + 2 * b][4], nib_q[base + 2 * b][3:0], nib_q[base + 2 * b + 1][3:0]};
        checkOutput($sformatf("%s_byte%0d", tag, b), got_b, exp_b);
      end
    end
  endtask

  initial begin
    host.lcd_row    = 1'b0;
    host.lcd_col    = '0;
    host.lcd_char   = '0;
    host.lcd_we     = 1'b0;
    host.lcd_update = 1'b0;
    for (int a = 0; a < 32; a++) model[a] = 8'h00;

    repeat (3) @(negedge CLK);
    checkOutput("rst_busy", host.lcd_busy, 1);
    checkOutput("rst_e", LCD_E, 0);
    checkOutput("rst_rs", LCD_RS, 0);
    checkOutput("rst_db", LCD_DB, 0);
    checkOutput("rst_rw", LCD_RW, 0);
    RST = 1'b0;
    nib_q.delete();
    waitIdle("init_cycles", 122);
    checkInit("init");

    for (int a = 0; a < 32; a++)
      applyStimulus(1'b1, a[4], a[3:0], 8'(32'h20 + a), 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd0, 8'h41, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd15, 8'h5A, 1'b0);
    nib_q.delete();
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    waitIdle("refresh_cycles", 476);
    checkOutput("refresh_nib_count", nib_q.size(), 68);
    checkRefresh("refresh1", 0);

    // Three updates during a refresh collapse into one back-to-back refresh.
    nib_q.delete();
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    cycles = 0;
    while (host.lcd_busy === 1'b1 && cycles < 5000) begin
      host.lcd_update = (cycles == 100 || cycles == 200 || cycles == 300);
      @(negedge CLK);
      cycles++;
    end
    host.lcd_update = 1'b0;
    checkOutput("pending_busy_cycles", cycles, 952);
    checkOutput("pending_nib_count", nib_q.size(), 136);
    checkRefresh("pend_a", 0);
    checkRefresh("pend_b", 68);
    repeat (50) @(negedge CLK);
    checkOutput("pending_no_third", host.lcd_busy, 0);

    // Write to row1 col5 early in a refresh; it must appear on the panel.
    nib_q.delete();
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    repeat (150) @(negedge CLK);
    applyStimulus(1'b1, 1'b1, 4'd5, 8'h55, 1'b0);
    waitIdle("midwrite_cycles", 325);
    checkRefresh("midwrite", 0);

    // Reset while E is high in byte 10, with a refresh pending.
    nib_q.delete();
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    repeat (19) @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    repeat (121) @(negedge CLK);
    checkOutput("byte10_e_high", LCD_E, 1);
    checkOutput("byte10_rs", LCD_RS, 1);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("abort_e", LCD_E, 0);
    checkOutput("abort_busy", host.lcd_busy, 1);
    checkOutput("abort_db", LCD_DB, 0);
    @(negedge CLK);
    RST = 1'b0;
    nib_q.delete();
    waitIdle("reinit_cycles", 122);
    checkInit("reinit");
    repeat (60) @(negedge CLK);
    checkOutput("reinit_no_pending", host.lcd_busy, 0);
    checkOutput("reinit_quiet_bus", nib_q.size(), 12);

    // Same-edge write and update in IDLE: the new char is sent.
    nib_q.delete();
    applyStimulus(1'b1, 1'b0, 4'd3, 8'h33, 1'b1);
    waitIdle("same_edge_cycles", 476);
    checkRefresh("same_edge", 0);
    checkOutput("e_pulse_width_errors", e_bad, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
